// File: rtl/arm_dp_alu.sv
// ARM data-processing ALU: 16 opcodes plus CLZ.
// One-cycle registered result and NZCV flags.
module arm_dp_alu (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] s_in,
    input  logic [31:0] t_in,
    input  logic [3:0]  alucontrol_in,
    input  logic        carry_in,
    input  logic        ctrl_clz_in,
    output logic [31:0] result_out,
    output logic        carry_flag_out,
    output logic        negative_flag_out,
    output logic        overflow_flag_out,
    output logic        zero_flag_out
);

    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic        is_arith;
    logic [32:0] sum;
    logic [5:0]  clz_cnt;
    logic [31:0] res_d;
    logic        c_d;
    logic        v_d;

    // Every arithmetic opcode maps onto one 33-bit adder: X + Y + cin.
    always_comb begin
        add_x    = '0;
        add_y    = '0;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        unique case (alucontrol_in)
            4'b0010, 4'b1010: begin
                add_x   = s_in;
                add_y   = ~t_in;
                add_cin = 1'b1;
            end
            4'b0011: begin
                add_x   = t_in;
                add_y   = ~s_in;
                add_cin = 1'b1;
            end
            4'b0100, 4'b1011: begin
                add_x   = s_in;
                add_y   = t_in;
                add_cin = 1'b0;
            end
            4'b0101: begin
                add_x   = s_in;
                add_y   = t_in;
                add_cin = carry_in;
            end
            4'b0110: begin
                add_x   = s_in;
                add_y   = ~t_in;
                add_cin = carry_in;
            end
            4'b0111: begin
                add_x   = t_in;
                add_y   = ~s_in;
                add_cin = carry_in;
            end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    // Highest set bit is visited last, so it sets the final count.
    always_comb begin
        clz_cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (t_in[i]) clz_cnt = 6'(31 - i);
        end
    end

    always_comb begin
        res_d = sum[31:0];
        c_d   = carry_in;
        v_d   = 1'b0;
        if (ctrl_clz_in) begin
            res_d = {26'd0, clz_cnt};
        end else if (is_arith) begin
            res_d = sum[31:0];
            c_d   = sum[32];
            v_d   = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end else begin
            unique case (alucontrol_in)
                4'b0000, 4'b1000: res_d = s_in & t_in;
                4'b0001, 4'b1001: res_d = s_in ^ t_in;
                4'b1100:          res_d = s_in | t_in;
                4'b1101:          res_d = t_in;
                4'b1110:          res_d = s_in & ~t_in;
                4'b1111:          res_d = ~t_in;
                default:          res_d = sum[31:0];
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            result_out        <= '0;
            carry_flag_out    <= 1'b0;
            negative_flag_out <= 1'b0;
            overflow_flag_out <= 1'b0;
            zero_flag_out     <= 1'b0;
        end else begin
            result_out        <= res_d;
            carry_flag_out    <= c_d;
            negative_flag_out <= res_d[31];
            overflow_flag_out <= v_d;
            zero_flag_out     <= (res_d == 32'd0);
        end
    end

endmodule

// File: tb/tb_arm_dp_alu.sv
// Bench for arm_dp_alu: directed steps then random ops,
// checked one cycle later against an integer-arithmetic model.
module tb_arm_dp_alu;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] s_in;
    logic [31:0] t_in;
    logic [3:0]  alucontrol_in;
    logic        carry_in;
    logic        ctrl_clz_in;
    logic [31:0] result_out;
    logic        carry_flag_out;
    logic        negative_flag_out;
    logic        overflow_flag_out;
    logic        zero_flag_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic        pend_valid = 1'b0;
    logic [35:0] pend_exp;
    string       pend_tag;

    always #5 clk_in = ~clk_in;

    arm_dp_alu dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .s_in              (s_in),
        .t_in              (t_in),
        .alucontrol_in     (alucontrol_in),
        .carry_in          (carry_in),
        .ctrl_clz_in       (ctrl_clz_in),
        .result_out        (result_out),
        .carry_flag_out    (carry_flag_out),
        .negative_flag_out (negative_flag_out),
        .overflow_flag_out (overflow_flag_out),
        .zero_flag_out     (zero_flag_out)
    );

    function automatic logic ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Packed as {result, N, Z, C, V}.
    function automatic logic [35:0] model(
        input logic [31:0] s, input logic [31:0] t,
        input logic [3:0] op, input logic c, input logic clz
    );
        longint unsigned us = 64'(s);
        longint unsigned ut = 64'(t);
        longint ss = longint'($signed(s));
        longint st = longint'($signed(t));
        longint unsigned cu = 64'(c);
        longint unsigned bu = 64'(!c);
        logic [31:0] r = '0;
        logic cf = c;
        logic vf = 1'b0;
        int n = 0;
        if (clz) begin
            for (int k = 31; k >= 0; k--) begin
                if (t[k]) break;
                n++;
            end
            r = 32'(n);
        end else begin
            case (op)
                4'd0, 4'd8:  r = s & t;
                4'd1, 4'd9:  r = s ^ t;
                4'd12:       r = s | t;
                4'd13:       r = t;
                4'd14:       r = s & ~t;
                4'd15:       r = ~t;
                4'd2, 4'd10: begin
                    r = 32'(us - ut); cf = us >= ut; vf = ovf(ss - st);
                end
                4'd3: begin
                    r = 32'(ut - us); cf = ut >= us; vf = ovf(st - ss);
                end
                4'd4, 4'd11: begin
                    r = 32'(us + ut); cf = (us + ut) > 64'hFFFF_FFFF;
                    vf = ovf(ss + st);
                end
                4'd5: begin
                    r = 32'(us + ut + cu); cf = (us + ut + cu) > 64'hFFFF_FFFF;
                    vf = ovf(ss + st + longint'(cu));
                end
                4'd6: begin
                    r = 32'(us - ut - bu); cf = us >= ut + bu;
                    vf = ovf(ss - st - longint'(bu));
                end
                default: begin
                    r = 32'(ut - us - bu); cf = ut >= us + bu;
                    vf = ovf(st - ss - longint'(bu));
                end
            endcase
        end
        return {r, r[31], (r == 32'd0), cf, vf};
    endfunction

    task automatic check_pending();
        logic [35:0] obs;
        obs = {result_out, negative_flag_out, zero_flag_out,
               carry_flag_out, overflow_flag_out};
        n_cmp++;
        assert (obs === pend_exp) else begin
            n_bad++;
            $error("FAIL %s: observed res=%h nzcv=%b expected res=%h nzcv=%b",
                   pend_tag, obs[35:4], obs[3:0], pend_exp[35:4], pend_exp[3:0]);
        end
    endtask

    // One call per cycle: checks the previous op, then presents a new one.
    task automatic step(
        input logic rst, input logic [31:0] s, input logic [31:0] t,
        input logic [3:0] op, input logic c, input logic clz, input string tag
    );
        @(negedge clk_in);
        if (pend_valid) check_pending();
        reset_in      = rst;
        s_in          = s;
        t_in          = t;
        alucontrol_in = op;
        carry_in      = c;
        ctrl_clz_in   = clz;
        pend_exp      = rst ? model(s, t, op, c, clz) : 36'd0;
        pend_tag      = tag;
        pend_valid    = 1'b1;
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        reset_in = 1'b0;
        s_in = '0; t_in = '0; alucontrol_in = '0;
        carry_in = 1'b0; ctrl_clz_in = 1'b0;

        step(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 1'b0, "reset0");
        step(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 1'b0, "reset1");
        step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 1'b0, "add_wrap");
        step(1'b1, 32'h8000_0000, 32'd1, 4'b0010, 1'b0, 1'b0, "sub_ovf");
        step(1'b1, 32'd1, 32'd2, 4'b1010, 1'b0, 1'b0, "cmp_neg");
        step(1'b1, 32'd5, 32'd3, 4'b0101, 1'b1, 1'b0, "adc");
        step(1'b1, 32'd5, 32'd3, 4'b0110, 1'b0, 1'b0, "sbc");
        step(1'b1, 32'd3, 32'd5, 4'b0111, 1'b1, 1'b0, "rsc");
        step(1'b1, 32'd3, 32'd5, 4'b0011, 1'b0, 1'b0, "rsb");
        step(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0100, 1'b0, 1'b0, "add_ovf");
        step(1'b1, 32'd9, 32'd7, 4'b1011, 1'b0, 1'b0, "cmn");
        step(1'b1, 32'h0, 32'h0, 4'b1111, 1'b1, 1'b0, "mvn");
        step(1'b1, 32'hFF, 32'h0F, 4'b1110, 1'b0, 1'b0, "bic");
        step(1'b1, 32'h1234, 32'h1234, 4'b1001, 1'b0, 1'b0, "teq");
        step(1'b1, 32'hF0F0, 32'h0FF0, 4'b1000, 1'b1, 1'b0, "tst");
        step(1'b1, 32'hF000, 32'h000F, 4'b1100, 1'b0, 1'b0, "orr");
        step(1'b1, 32'h5, 32'hA5A5, 4'b1101, 1'b1, 1'b0, "mov");
        step(1'b1, 32'hFFFF, 32'h00010000, 4'b0100, 1'b0, 1'b1, "clz15");
        step(1'b1, 32'hFFFF, 32'h0, 4'b0100, 1'b1, 1'b1, "clz32");
        step(1'b1, 32'hFFFF, 32'h8000_0000, 4'b0100, 1'b0, 1'b1, "clz0");
        step(1'b1, 32'hFFFF, 32'd1, 4'b0100, 1'b0, 1'b1, "clz31");
        step(1'b1, 32'd10, 32'd20, 4'b0100, 1'b0, 1'b0, "b2b_add");
        step(1'b1, 32'd10, 32'd20, 4'b0010, 1'b0, 1'b0, "b2b_sub");
        step(1'b1, 32'd10, 32'h0000_0400, 4'b0000, 1'b0, 1'b1, "b2b_clz");
        step(1'b1, 32'hFF00, 32'h0FF0, 4'b0000, 1'b0, 1'b0, "b2b_and");

        for (int i = 0; i < 600; i++) begin
            rs = $urandom();
            rt = $urandom();
            if ($urandom_range(0, 3) == 0) rs = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rt = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) rt = rt >> $urandom_range(0, 31);
            step(($urandom_range(0, 49) != 0), rs, rt,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), "random");
        end

        step(1'b1, 32'd0, 32'd0, 4'b1101, 1'b0, 1'b0, "flush");
        @(negedge clk_in);
        check_pending();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
